fsmc_bus_slave: RTL and testbench
=================================

Name: fsmc_bus_slave

Overview:
Parametrised successor to the FSMC clocked bus slave. It synchronises the STM32 FSMC strobes into the `clk` domain and emits single-cycle `do_write`/`do_read` strobes to the register decoder. It drives the read data onto the tristate data bus. New over the previous generation:
- byte-lane enables (aNBL)
- variable-latency read handshake (rd_ack), with timeout
- configurable synchroniser depth
- saturating abort counter

Parameters:
- ADRW, 8: address width
- DATW, 16: data width; must be a multiple of 8
- SYNC_STAGES, 2: flops per strobe synchroniser; must be >= 2
- RD_TIMEOUT, 15: max `clk` cycles in RD_WAIT before forced completion; range 1..255
- TIMEOUT_DATA, all ones: value returned on a read timeout

Ports:
- clk  in  1  system clock (PLL output)
- nrst  in  1  reset; asynchronous, active-low
- aNE  in  1  chip select, active-low, async
- aNOE  in  1  output enable, active-low, async
- aNWE  in  1  write enable, active-low, async
- aNBL  in  DATW/8  byte-lane enables, active-low, async
- aAn  in  ADRW  address, async
- aDn  in  DATW  data from the SB_IO D_IN_0 pins
- io_output  out  1  tristate output enable for the data pins
- io_data  out  DATW  data to the SB_IO D_OUT_0 pins
- w_adr  out  ADRW  latched write address
- w_data  out  DATW  latched write data
- w_be  out  DATW/8  latched byte enables, active-high
- do_write  out  1  one-cycle write strobe
- r_adr  out  ADRW  latched read address
- do_read  out  1  one-cycle read strobe
- read_data  in  DATW  register data from the decoder
- rd_ack  in  1  read_data valid
- rd_timeout  out  1  one-cycle pulse on forced read completion
- abort_cnt  out  8  saturating count of reads abandoned before ack

Behaviour:
- Reset:
  - Reset is asynchronous, active-low.
  - All outputs go to 0 immediately, including `io_output`, so the bus is released on reset mid-read.
  - All address/data/byte-enable latches and `abort_cnt` clear to 0.
  - State goes to IDLE.
- Synchronisation:
  - sNE, sNOE and sNWE each pass through SYNC_STAGES flops; these flops reset to 1.
  - aAn, aDn and aNBL are sampled unsynchronised, only at the latch points below; they are stable by then.
- Let E = ~sNE.
- IDLE:
  - E & ~sNWE → WRITE. On that edge, latch w_adr = aAn, w_data = aDn, w_be = ~aNBL, and assert do_write for exactly one cycle.
  - Otherwise, E & ~sNOE → RD_WAIT. Latch r_adr = aAn and assert do_read for exactly one cycle.
  - If sNWE and sNOE are both low, write wins.
- WRITE: stay while E & ~sNWE; otherwise → IDLE. No second strobe within one transaction.
- RD_WAIT:
  - A wait counter is cleared on entry and increments each cycle.
  - rd_ack is sampled every RD_WAIT cycle, including the cycle do_read is high, so a combinational decode with rd_ack tied to 1 gives previous-generation timing.
  - Exit conditions are evaluated in priority order:
    1. Strobe released (sNE | sNOE): → IDLE; abort_cnt += 1, saturating at 255.
    2. rd_ack: latch io_data = read_data; → RD_DRIVE.
    3. Counter == RD_TIMEOUT-1: latch io_data = TIMEOUT_DATA, pulse rd_timeout; → RD_DRIVE.
- RD_DRIVE:
  - Stay while E & ~sNOE; otherwise → IDLE.
  - io_output = (state == RD_DRIVE) & E & ~sNOE, using registered synchronised signals, so it deasserts in the same cycle the release is seen.
- Latency:
  - aNWE or aNOE falling edge to do_write/do_read: SYNC_STAGES+1 clk edges.
  - rd_ack to io_output high: 1 cycle.
- io_data holds its last value outside RD_DRIVE.
- w_* and r_adr hold until the next transaction of the same type.
- Back-to-back transactions are legal: an IDLE cycle between them is guaranteed by strobe deassertion.

Decomposition:
- Package `fsmc_pkg`:
  - state encoding constants IDLE, WRITE, RD_WAIT, RD_DRIVE (one-hot, 4 bits)
  - default TIMEOUT_DATA
  - the abort counter width constant (8)
- Sub-module `sync_chain` #(W, STAGES): async active-low reset to a RESET_VAL parameter. It replaces the fixed two-flop synchroniser. Instantiate once with W=3 for NE/NOE/NWE.

Test Plan:
1. Write with aA=0x02, aD=0xA55A, aNBL=2'b01 → exactly one do_write, SYNC_STAGES+1 cycles after aNWE falls; w_adr=0x02, w_data=0xA55A, w_be=2'b10; returns to IDLE after aNWE rises.
2. Read with aA=0x10, rd_ack tied 1, read_data=0x1234 → one do_read, r_adr=0x10; io_output rises 1 cycle later with io_data=0x1234; io_output falls the cycle sNOE is seen high.
3. Read with rd_ack asserted 5 cycles after do_read, read_data=0xBEEF → io_output stays 0 for those 5 cycles, then drives 0xBEEF; rd_timeout stays 0.
4. Read with rd_ack never asserted, RD_TIMEOUT=15 → rd_timeout pulses once 15 cycles after entering RD_WAIT; io_data=0xFFFF is driven.
5. Raise aNOE before rd_ack, repeated 300 times → no drive ever occurs; abort_cnt counts up and saturates at 255.
6. Drop nrst during RD_DRIVE → io_output=0 asynchronously, before the next clk edge; after release, state is IDLE, all latches 0, and the next write works normally.

Source files
------------

// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC clocked bus slave.
package fsmc_pkg;

  // One-hot transaction state encoding.
  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    WRITE    = 4'b0010,
    RD_WAIT  = 4'b0100,
    RD_DRIVE = 4'b1000
  } fsmc_state_t;

  // Wide all-ones pattern; the top slices it to DATW for the read-timeout value.
  localparam logic [255:0] TIMEOUT_DATA_DFLT = '1;

  // Width of the saturating abort counter.
  localparam int unsigned ABORT_W = 8;

endpackage

// File: rtl/fsmc_bus_slave_sync_chain.sv
// Multi-flop synchroniser for W independent single-bit asynchronous signals.
module sync_chain #(
  parameter int unsigned   W         = 1,
  parameter int unsigned   STAGES    = 2,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] chain;

  // Shift the asynchronous inputs through STAGES flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fsmc_bus_slave.sv
// FSMC clocked bus slave: synchronises the FSMC strobes, emits single-cycle
// write/read strobes, and drives read data with a variable-latency handshake.
module fsmc_bus_slave
  import fsmc_pkg::*;
#(
  parameter int unsigned      ADRW         = 8,
  parameter int unsigned      DATW         = 16,
  parameter int unsigned      SYNC_STAGES  = 2,
  parameter int unsigned      RD_TIMEOUT   = 15,
  parameter logic [DATW-1:0]  TIMEOUT_DATA = TIMEOUT_DATA_DFLT[DATW-1:0]
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 aNE,
  input  logic                 aNOE,
  input  logic                 aNWE,
  input  logic [DATW/8-1:0]    aNBL,
  input  logic [ADRW-1:0]      aAn,
  input  logic [DATW-1:0]      aDn,
  output logic                 io_output,
  output logic [DATW-1:0]      io_data,
  output logic [ADRW-1:0]      w_adr,
  output logic [DATW-1:0]      w_data,
  output logic [DATW/8-1:0]    w_be,
  output logic                 do_write,
  output logic [ADRW-1:0]      r_adr,
  output logic                 do_read,
  input  logic [DATW-1:0]      read_data,
  input  logic                 rd_ack,
  output logic                 rd_timeout,
  output logic [ABORT_W-1:0]   abort_cnt
);

  localparam logic [7:0] WAIT_LAST = 8'(RD_TIMEOUT - 1);

  logic [2:0]  s_sync;
  logic        sne, snoe, snwe, e;
  fsmc_state_t state, state_next;
  logic [7:0]  wait_cnt;
  logic        write_go, read_go, abort_go, ack_go, timeout_go;

  sync_chain #(
    .W         (3),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (3'b111)
  ) u_sync (
    .clk   (clk),
    .rst_n (nrst),
    .d     ({aNWE, aNOE, aNE}),
    .q     (s_sync)
  );

  assign {snwe, snoe, sne} = s_sync;
  assign e = ~sne;

  // Bus is driven only while the synchronised read strobe is still active,
  // so it releases in the same cycle the host release is observed.
  assign io_output = (state == RD_DRIVE) & e & ~snoe;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and transaction events.
  always_comb begin
    state_next = state;
    write_go   = 1'b0;
    read_go    = 1'b0;
    abort_go   = 1'b0;
    ack_go     = 1'b0;
    timeout_go = 1'b0;
    case (state)
      IDLE: begin
        if (e && !snwe) begin
          state_next = WRITE;
          write_go   = 1'b1;
        end else if (e && !snoe) begin
          state_next = RD_WAIT;
          read_go    = 1'b1;
        end
      end
      WRITE: begin
        if (!(e && !snwe)) state_next = IDLE;
      end
      RD_WAIT: begin
        if (sne || snoe) begin
          state_next = IDLE;
          abort_go   = 1'b1;
        end else if (rd_ack) begin
          state_next = RD_DRIVE;
          ack_go     = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = RD_DRIVE;
          timeout_go = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (!(e && !snoe)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latches, strobes, wait counter and abort counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      w_adr      <= '0;
      w_data     <= '0;
      w_be       <= '0;
      do_write   <= 1'b0;
      r_adr      <= '0;
      do_read    <= 1'b0;
      io_data    <= '0;
      rd_timeout <= 1'b0;
      abort_cnt  <= '0;
      wait_cnt   <= '0;
    end else begin
      do_write   <= write_go;
      do_read    <= read_go;
      rd_timeout <= timeout_go;
      if (write_go) begin
        w_adr  <= aAn;
        w_data <= aDn;
        w_be   <= ~aNBL;
      end
      if (read_go) begin
        r_adr    <= aAn;
        wait_cnt <= '0;
      end else if (state == RD_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (ack_go)          io_data <= read_data;
      else if (timeout_go) io_data <= TIMEOUT_DATA;
      if (abort_go && (abort_cnt != '1)) abort_cnt <= abort_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fsmc_bus_slave.sv
// Directed testbench for fsmc_bus_slave with hand-computed expectations.
module tb_fsmc_bus_slave;

  logic        clk = 1'b0;
  logic        nrst;
  logic        aNE, aNOE, aNWE;
  logic [1:0]  aNBL;
  logic [7:0]  aAn;
  logic [15:0] aDn;
  logic        io_output;
  logic [15:0] io_data;
  logic [7:0]  w_adr;
  logic [15:0] w_data;
  logic [1:0]  w_be;
  logic        do_write;
  logic [7:0]  r_adr;
  logic        do_read;
  logic [15:0] read_data;
  logic        rd_ack;
  logic        rd_timeout;
  logic [7:0]  abort_cnt;

  int n_checks = 0;
  int n_bad    = 0;

  int rd_at, drive_at, to_at, rd_cnt, to_cnt, wr_at, wr_cnt, drive_seen;
  logic [15:0] drv_data;

  fsmc_bus_slave #(
    .ADRW        (8),
    .DATW        (16),
    .SYNC_STAGES (2),
    .RD_TIMEOUT  (15)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .aNE        (aNE),
    .aNOE       (aNOE),
    .aNWE       (aNWE),
    .aNBL       (aNBL),
    .aAn        (aAn),
    .aDn        (aDn),
    .io_output  (io_output),
    .io_data    (io_data),
    .w_adr      (w_adr),
    .w_data     (w_data),
    .w_be       (w_be),
    .do_write   (do_write),
    .r_adr      (r_adr),
    .do_read    (do_read),
    .read_data  (read_data),
    .rd_ack     (rd_ack),
    .rd_timeout (rd_timeout),
    .abort_cnt  (abort_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Starts a write at a negedge and watches n_iter negedges.
  task automatic run_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] nbl,
                           input int n_iter);
    wr_at = 0; wr_cnt = 0;
    aAn = a; aDn = d; aNBL = nbl; aNE = 1'b0; aNWE = 1'b0;
    for (int i = 1; i <= n_iter; i++) begin
      @(negedge clk);
      if (do_write && wr_at == 0) wr_at = i;
      if (do_write) wr_cnt++;
    end
  endtask

  // Starts a read at a negedge; ack_iter>0 raises rd_ack after that sample,
  // ack_iter==0 ties rd_ack high, ack_iter<0 never acknowledges.
  task automatic run_read(input logic [7:0] a, input logic [15:0] d, input int ack_iter,
                          input int n_iter);
    rd_at = 0; drive_at = 0; to_at = 0; rd_cnt = 0; to_cnt = 0; drv_data = '0;
    aAn = a; read_data = d; rd_ack = (ack_iter == 0);
    aNE = 1'b0; aNOE = 1'b0;
    for (int i = 1; i <= n_iter; i++) begin
      @(negedge clk);
      if (do_read && rd_at == 0) rd_at = i;
      if (do_read) rd_cnt++;
      if (io_output && drive_at == 0) begin
        drive_at = i;
        drv_data = io_data;
      end
      if (rd_timeout && to_at == 0) to_at = i;
      if (rd_timeout) to_cnt++;
      if (ack_iter > 0 && i == ack_iter) rd_ack = 1'b1;
    end
  endtask

  task automatic release_bus;
    aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1; rd_ack = 1'b0;
    idle_cycles(4);
  endtask

  initial begin
    nrst = 1'b0; aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1; aNBL = 2'b11;
    aAn = '0; aDn = '0; read_data = '0; rd_ack = 1'b0;
    idle_cycles(2);
    check("rst_io_output", 32'(io_output), 32'h0);
    check("rst_do_write", 32'(do_write), 32'h0);
    check("rst_abort_cnt", 32'(abort_cnt), 32'h0);
    check("rst_state", 32'(dut.state), 32'h1);
    nrst = 1'b1;
    idle_cycles(2);

    // 1: write, latency SYNC_STAGES+1 = 3 edges, single strobe
    run_write(8'h02, 16'hA55A, 2'b01, 8);
    check("t1_wr_latency", 32'(wr_at), 32'd3);
    check("t1_wr_count", 32'(wr_cnt), 32'd1);
    check("t1_w_adr", 32'(w_adr), 32'h02);
    check("t1_w_data", 32'(w_data), 32'hA55A);
    check("t1_w_be", 32'(w_be), 32'h2);
    release_bus();
    check("t1_idle", 32'(dut.state), 32'h1);

    // 2: read, rd_ack tied high
    run_read(8'h10, 16'h1234, 0, 6);
    check("t2_rd_latency", 32'(rd_at), 32'd3);
    check("t2_rd_count", 32'(rd_cnt), 32'd1);
    check("t2_r_adr", 32'(r_adr), 32'h10);
    check("t2_drive_at", 32'(drive_at), 32'd4);
    check("t2_drive_data", 32'(drv_data), 32'h1234);
    aNOE = 1'b1;
    @(negedge clk);
    check("t2_drive_hold", 32'(io_output), 32'h1);
    @(negedge clk);
    check("t2_drive_release", 32'(io_output), 32'h0);
    release_bus();

    // 3: ack five cycles after do_read
    run_read(8'h20, 16'hBEEF, 8, 12);
    check("t3_rd_latency", 32'(rd_at), 32'd3);
    check("t3_drive_at", 32'(drive_at), 32'd9);
    check("t3_drive_data", 32'(drv_data), 32'hBEEF);
    check("t3_timeout_cnt", 32'(to_cnt), 32'd0);
    release_bus();

    // 4: no ack, forced completion 15 cycles after RD_WAIT entry
    run_read(8'h30, 16'h0000, -1, 24);
    check("t4_timeout_at", 32'(to_at), 32'd18);
    check("t4_timeout_cnt", 32'(to_cnt), 32'd1);
    check("t4_drive_at", 32'(drive_at), 32'd18);
    check("t4_drive_data", 32'(drv_data), 32'hFFFF);
    check("t4_io_data", 32'(io_data), 32'hFFFF);
    release_bus();

    // 5: abandoned reads, saturating counter
    drive_seen = 0;
    for (int n = 1; n <= 300; n++) begin
      aAn = 8'h40; rd_ack = 1'b0; aNE = 1'b0; aNOE = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (io_output) drive_seen++;
      end
      aNE = 1'b1; aNOE = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (io_output) drive_seen++;
      end
      if (n == 10) check("t5_abort_10", 32'(abort_cnt), 32'd10);
      if (n == 255) check("t5_abort_255", 32'(abort_cnt), 32'd255);
    end
    check("t5_abort_sat", 32'(abort_cnt), 32'd255);
    check("t5_no_drive", 32'(drive_seen), 32'd0);

    // 6: asynchronous reset during RD_DRIVE
    run_read(8'h50, 16'h5A5A, 0, 6);
    check("t6_driving", 32'(io_output), 32'h1);
    #2 nrst = 1'b0;
    #1;
    check("t6_async_release", 32'(io_output), 32'h0);
    check("t6_w_adr", 32'(w_adr), 32'h0);
    check("t6_w_data", 32'(w_data), 32'h0);
    check("t6_w_be", 32'(w_be), 32'h0);
    check("t6_r_adr", 32'(r_adr), 32'h0);
    check("t6_io_data", 32'(io_data), 32'h0);
    check("t6_abort_cnt", 32'(abort_cnt), 32'h0);
    aNE = 1'b1; aNOE = 1'b1; rd_ack = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    idle_cycles(2);
    check("t6_state", 32'(dut.state), 32'h1);
    run_write(8'h33, 16'h1357, 2'b10, 8);
    check("t6_wr_latency", 32'(wr_at), 32'd3);
    check("t6_wr_count", 32'(wr_cnt), 32'd1);
    check("t6_wr_adr", 32'(w_adr), 32'h33);
    check("t6_wr_data", 32'(w_data), 32'h1357);
    check("t6_wr_be", 32'(w_be), 32'h1);
    release_bus();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
